// File: rtl/rr_arb8_if.sv
// rr_arb8_if: request/grant bundle for the 8-way round-robin arbiter.
// The lock signal exists only when RR_ARB8_LOCK_EN is defined.
interface rr_arb8_if;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
`ifdef RR_ARB8_LOCK_EN
  logic       lock;

  modport master (output req, output lock, input gnt, input gnt_idx, input gnt_valid);
  modport slave  (input req, input lock, output gnt, output gnt_idx, output gnt_valid);
`else
  modport master (output req, input gnt, input gnt_idx, input gnt_valid);
  modport slave  (input req, output gnt, output gnt_idx, output gnt_valid);
`endif
endinterface

// File: rtl/rr_arb8.sv
// rr_arb8: 8-requester round-robin arbiter with bounded hold time.
// A holder keeps the grant while requesting, but is preempted after
// MAX_HOLD consecutive cycles if anyone else is waiting. All outputs are
// registered, so req never reaches gnt combinationally.
// Optional feature macro: RR_ARB8_LOCK_EN (adds a lock input that lets the
// current holder suppress preemption; release still hands over normally).
module rr_arb8 #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic     clk,
  input  logic     rst,
  rr_arb8_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] idx;
  logic [2:0] idx_nxt;
  logic [2:0] ptr;
  logic [2:0] ptr_nxt;
  logic [3:0] hcnt;
  logic [3:0] hcnt_nxt;
  logic       valid;
  logic       valid_nxt;
  logic [7:0] gnt;
  logic [7:0] gnt_nxt;
  logic [7:0] others;
  logic [3:0] pick_all;
  logic [3:0] pick_oth;
  logic       holder_on;
  logic       hand_off;
  logic       lock_active;

  // 3-to-8 one-hot decode
  function automatic logic [7:0] decode(input logic [2:0] sel);
    logic [7:0] onehot;
    onehot = 8'h00;
    onehot[sel] = 1'b1;
    return onehot;
  endfunction

  // First set bit of cand searching upward from start with wrap;
  // bit 3 of the result flags that a winner exists.
  function automatic logic [3:0] pick(input logic [7:0] cand, input logic [2:0] start);
    logic [3:0] res;
    logic [2:0] pos;
    res = 4'd0;
    // Walk from the farthest offset down so the nearest hit overwrites last
    for (int i = 7; i >= 0; i--) begin
      pos = start + 3'(i);
      res = cand[pos] ? {1'b1, pos} : res;
    end
    return res;
  endfunction

`ifdef RR_ARB8_LOCK_EN
  assign lock_active = bus.lock;
`else
  assign lock_active = 1'b0;
`endif

  // Next-state, next-grant and pointer/hold bookkeeping
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    ptr_nxt   = ptr;
    hcnt_nxt  = hcnt;
    valid_nxt = valid;
    // The current holder never competes in its own hand-off
    others    = bus.req & ~decode(idx);
    pick_all  = pick(bus.req, ptr);
    pick_oth  = pick(others, ptr);
    holder_on = bus.req[idx];
    hand_off  = !holder_on || ((hcnt == HOLD_LAST) && !lock_active);

    case (state)
      IDLE: begin
        if (pick_all[3]) begin
          state_nxt = BUSY;
          idx_nxt   = pick_all[2:0];
          ptr_nxt   = pick_all[2:0] + 3'd1;
          hcnt_nxt  = 4'd0;
          valid_nxt = 1'b1;
        end else begin
          state_nxt = IDLE;
          idx_nxt   = 3'd0;
          hcnt_nxt  = 4'd0;
          valid_nxt = 1'b0;
        end
      end
      BUSY: begin
        if (hand_off && pick_oth[3]) begin
          // Release or preemption straight into the next winner, no bubble
          state_nxt = BUSY;
          idx_nxt   = pick_oth[2:0];
          ptr_nxt   = pick_oth[2:0] + 3'd1;
          hcnt_nxt  = 4'd0;
          valid_nxt = 1'b1;
        end else if (!holder_on) begin
          state_nxt = IDLE;
          idx_nxt   = 3'd0;
          hcnt_nxt  = 4'd0;
          valid_nxt = 1'b0;
        end else begin
          // Retained: count held cycles, saturating at the preemption point
          state_nxt = BUSY;
          hcnt_nxt  = (hcnt == HOLD_LAST) ? hcnt : (hcnt + 4'd1);
          valid_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = 3'd0;
        ptr_nxt   = 3'd0;
        hcnt_nxt  = 4'd0;
        valid_nxt = 1'b0;
      end
    endcase

    gnt_nxt = valid_nxt ? decode(idx_nxt) : 8'h00;
  end

  // State and registered outputs; reset drops any grant immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= 3'd0;
      ptr   <= 3'd0;
      hcnt  <= 4'd0;
      valid <= 1'b0;
      gnt   <= 8'h00;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      ptr   <= ptr_nxt;
      hcnt  <= hcnt_nxt;
      valid <= valid_nxt;
      gnt   <= gnt_nxt;
    end
  end

  assign bus.gnt       = gnt;
  assign bus.gnt_idx   = idx;
  assign bus.gnt_valid = valid;

endmodule

// File: tb/tb_rr_arb8.sv
// tb_rr_arb8: directed scoreboard bench for rr_arb8.
// u_dut0 uses MAX_HOLD=4, u_dut1 uses MAX_HOLD=1 for the rotation case.
module tb_rr_arb8;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  logic [7:0] sb[$];

  rr_arb8_if ifc0 ();
  rr_arb8_if ifc1 ();

  rr_arb8 #(.MAX_HOLD(4)) u_dut0 (.clk(clk), .rst(rst), .bus(ifc0));
  rr_arb8 #(.MAX_HOLD(1)) u_dut1 (.clk(clk), .rst(rst), .bus(ifc1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input logic [7:0] g, input int n);
    for (int k = 0; k < n; k++) sb.push_back(g);
  endtask

  task automatic check(input string tag, input logic [7:0] g, input logic [2:0] i, input logic v);
    logic [7:0] e;
    logic [2:0] ei;
    logic       ev;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: scoreboard empty, got gnt %h", tag, g);
    end else begin
      e  = sb.pop_front();
      ev = (e != 8'h00);
      ei = 3'd0;
      for (int k = 0; k < 8; k++) if (e[k]) ei = 3'(k);
      tests++;
      assert (g === e) else begin
        fails++;
        $error("FAIL %s gnt: got %h, expected %h", tag, g, e);
      end
      tests++;
      assert (i === ei) else begin
        fails++;
        $error("FAIL %s gnt_idx: got %0d, expected %0d", tag, i, ei);
      end
      tests++;
      assert (v === ev) else begin
        fails++;
        $error("FAIL %s gnt_valid: got %b, expected %b", tag, v, ev);
      end
    end
  endtask

  task automatic run0(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      check(tag, ifc0.gnt, ifc0.gnt_idx, ifc0.gnt_valid);
    end
  endtask

  task automatic run1(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      check(tag, ifc1.gnt, ifc1.gnt_idx, ifc1.gnt_valid);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    ifc0.req = 8'hFF;
    ifc1.req = 8'hFF;
`ifdef RR_ARB8_LOCK_EN
    ifc0.lock = 1'b0;
    ifc1.lock = 1'b0;
`endif

    // Outputs stay zero while reset is held, even with all requests high
    @(posedge clk);
    @(posedge clk);
    #1;
    push(8'h00, 1);
    check("rst_hold0", ifc0.gnt, ifc0.gnt_idx, ifc0.gnt_valid);
    push(8'h00, 1);
    check("rst_hold1", ifc1.gnt, ifc1.gnt_idx, ifc1.gnt_valid);

    // Idle with no requests
    rst = 1'b0;
    ifc0.req = 8'h00;
    ifc1.req = 8'h00;
    push(8'h00, 5);
    run0("idle", 5);

    // Two requesters, hold limit 4: 2,5,2
    ifc0.req = 8'h24;
    push(8'h04, 4);
    push(8'h20, 4);
    push(8'h04, 4);
    run0("rr_24", 12);

    // Release with nobody waiting -> idle (ptr now 3)
    ifc0.req = 8'h00;
    push(8'h00, 1);
    run0("release_idle", 1);

    // Lone requester holds indefinitely
    ifc0.req = 8'h80;
    push(8'h80, 20);
    run0("hold_80", 20);

    // Holder drops while 0 requests: wrap to 0 with no bubble
    ifc0.req = 8'h01;
    push(8'h01, 2);
    run0("wrap_01", 2);

    // Grant idx 3 (ptr is 1 now)
    ifc0.req = 8'h00;
    push(8'h00, 1);
    run0("idle2", 1);
    ifc0.req = 8'h08;
    push(8'h08, 2);
    run0("gnt_3", 2);

    // Mid-cycle async reset drops the grant before the next edge
    #3;
    rst = 1'b1;
    #1;
    push(8'h00, 1);
    check("async_rst", ifc0.gnt, ifc0.gnt_idx, ifc0.gnt_valid);
    @(posedge clk);
    #1;
    rst = 1'b0;
    // From ptr 0 the first of {3,4} is 3; a stale ptr of 4 would pick 4
    ifc0.req = 8'h18;
    push(8'h08, 4);
    push(8'h10, 1);
    run0("post_rst_18", 5);

    // MAX_HOLD=1: pure per-cycle rotation over all eight
    ifc1.req = 8'hFF;
    push(8'h01, 1);
    push(8'h02, 1);
    push(8'h04, 1);
    push(8'h08, 1);
    push(8'h10, 1);
    push(8'h20, 1);
    push(8'h40, 1);
    push(8'h80, 1);
    push(8'h01, 1);
    push(8'h02, 1);
    run1("rot_ff", 10);

    // From idle with ptr 5, req 06 picks idx 1
    ifc0.req = 8'h00;
    push(8'h00, 1);
    run0("idle3", 1);
    ifc0.req = 8'h06;
`ifdef RR_ARB8_LOCK_EN
    ifc0.lock = 1'b1;
    push(8'h02, 10);
    run0("lock_hold", 10);
    ifc0.lock = 1'b0;
    push(8'h04, 1);
    run0("unlock_move", 1);
`else
    push(8'h02, 4);
    push(8'h04, 4);
    push(8'h02, 1);
    run0("preempt_06", 9);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_arb8.md
RR_ARB8 -- requirements
Module: rr_arb8

Interface
REQ-001 Parameter MAX_HOLD, default 4: maximum consecutive grant cycles before preemption when other requests pend; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req  input  8  request per requester; bit i = requester i.
REQ-005 gnt  output  8  one-hot grant, registered; all-zero when nothing granted.
REQ-006 gnt_idx  output  3  binary index of granted requester, registered; 3'd0 when gnt_valid=0.
REQ-007 gnt_valid  output  1  high exactly when gnt is non-zero.
REQ-008 lock  input  1  (RR_ARB8_LOCK_EN only) holder asserts to suppress preemption.

Function
REQ-009 The FSM SHALL have two states: IDLE (no grant) and BUSY (one grant held).
REQ-010 gnt SHALL always equal the 3-to-8 one-hot decode of gnt_idx when gnt_valid=1, and SHALL be 8'h00 otherwise.
REQ-011 Winner selection SHALL be round-robin: the first set bit of req, searching upward from pointer ptr (3 bits) with wrap 7->0.
REQ-012 IDLE with req!=0 at edge N -> BUSY, gnt to winner, visible after edge N (one-cycle latency).
REQ-013 IDLE with req==0 -> remain IDLE, outputs zero.
REQ-014 On every new grant to index k, ptr SHALL become k+1 mod 8 (7 wraps to 0).
REQ-015 Hold counter hcnt (4 bits) SHALL clear to 0 on each new grant and increment each BUSY cycle the grant is retained, saturating at MAX_HOLD-1.
REQ-016 BUSY, req[gnt_idx]=0: release; if other requests pending, grant new winner at next edge with no idle bubble; else -> IDLE.
REQ-017 BUSY, req[gnt_idx]=1, hcnt==MAX_HOLD-1, other requests pending: preempt; grant next winner from ptr at next edge.
REQ-018 BUSY, req[gnt_idx]=1, no other requests: grant SHALL be retained indefinitely; hcnt saturates.
REQ-019 Preemption and release arbitrate excluding the current holder; holder re-requesting competes at its rotated priority.
REQ-020 MAX_HOLD=1: preempt after every granted cycle when others pend (pure per-cycle rotation).
REQ-021 Request bits changing in the cycle of a grant decision SHALL use the value sampled at that edge only; no combinational req->gnt path.
REQ-022 At most one gnt bit SHALL ever be high.

Reset
REQ-023 rst=1 SHALL immediately (asynchronously) force state=IDLE, gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, ptr=3'd0, hcnt=0.
REQ-024 Reset asserted mid-grant SHALL drop the grant without a release cycle; first arbitration after deassertion starts from ptr=0.
REQ-025 Outputs SHALL remain zero while rst=1 regardless of req.

Configuration
REQ-026 Macro RR_ARB8_LOCK_EN: when defined, lock port exists; lock=1 in BUSY with req[gnt_idx]=1 suppresses REQ-017 preemption (hcnt still saturates); release by REQ-016 still applies.
REQ-027 Without RR_ARB8_LOCK_EN: no lock port; preemption per REQ-017 unconditionally.

Verification
REQ-028 rst then req=8'h00 for 5 cycles -> gnt=8'h00, gnt_valid=0 throughout.
REQ-029 req=8'h24 held, MAX_HOLD=4 -> gnt 8'h04 for 4 cycles, 8'h20 for 4 cycles, 8'h04 again; gnt_idx 2,5,2.
REQ-030 req=8'h80 alone held 20 cycles -> gnt=8'h80 continuously, gnt_idx=7; then req=8'h01 added, 8'h80 dropped -> gnt=8'h01 next cycle (wrap, no bubble).
REQ-031 req=8'hFF, MAX_HOLD=1 -> gnt cycles 01,02,04,...,80,01 one per clock.
REQ-032 Granted to idx 3, assert rst mid-cycle -> gnt=0 before next edge; release rst with req=8'h18 -> first grant idx 3 (from ptr 0).
REQ-033 RR_ARB8_LOCK_EN, req=8'h06, lock=1 while idx 1 holds 10 cycles -> no preemption; lock=0 -> grant moves to idx 2 within MAX_HOLD cycles.
